// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller slice: bus widths, SDRAM
// command codes ({cs_n,ras_n,cas_n,we_n}), the arbiter state encoding and
// the command-bundle struct that the arbiter muxes onto the pins.
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam int CMD_W  = 4;
    localparam int BA_W   = 2;
    localparam int ADDR_W = 11;
    localparam int DQ_W   = 16;

    // SDRAM command codes, {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] NOP       = 4'b0111;
    localparam logic [CMD_W-1:0] P_CHARGE  = 4'b0010;
    localparam logic [CMD_W-1:0] A_REF     = 4'b0001;
    localparam logic [CMD_W-1:0] ACTIVE    = 4'b0011;
    localparam logic [CMD_W-1:0] WRITE     = 4'b0100;
    localparam logic [CMD_W-1:0] READ      = 4'b0101;
    localparam logic [CMD_W-1:0] M_REG_SET = 4'b0000;
    localparam logic [CMD_W-1:0] B_STOP    = 4'b0110;

    // Codes 5..7 are unused and recover to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } sdram_cmd_t;

    // Bundle driven while the arbiter is deciding: NOP, all-ones bank/address.
    localparam sdram_cmd_t ARBIT_BUNDLE = '{cmd: NOP, ba: '1, addr: '1};

    function automatic sdram_cmd_t mk_cmd(input logic [CMD_W-1:0] c,
                                          input logic [BA_W-1:0] b,
                                          input logic [ADDR_W-1:0] a);
        sdram_cmd_t r;
        r.cmd  = c;
        r.ba   = b;
        r.addr = a;
        return r;
    endfunction

endpackage

// File: rtl/sdram_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_arbit_if
// Bundles the stage-side request/command signals and the SDRAM pin outputs
// of the arbiter. The bidirectional data bus stays a plain port on the top.
//   slave  : arbiter view (requests/bundles in, grants/pins out)
//   master : stage/board view (requests/bundles out, grants/pins in)
// ---------------------------------------------------------------------------
interface sdram_arbit_if;
    import sdram_pkg::*;

    // init stage
    logic [CMD_W-1:0]  init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    // auto-refresh stage
    logic              aref_req;
    logic [CMD_W-1:0]  aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_end;
    // write stage
    logic              wr_req;
    logic              wr_end;
    logic [CMD_W-1:0]  wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DQ_W-1:0]   wr_sdram_data;
    // read stage
    logic              rd_req;
    logic              rd_end;
    logic [CMD_W-1:0]  rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    // grants
    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    // SDRAM pins
    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr
    );

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr
    );

endinterface

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
// Arbitrates SDRAM access between the init, auto-refresh, write and read
// stages. After init_end the FSM parks in ARBIT and grants one stage at a
// time (refresh > write > read); a grant is held until that stage's *_end
// pulse, after which ARBIT runs for at least one cycle before the next grant.
// The selected stage's command bundle is muxed onto the SDRAM pins.
// Ports:
//   sys_clk    in     system clock, rising edge
//   sys_rst_n  in     asynchronous active-low reset
//   bus        slave  requests/bundles in, grants and SDRAM pins out
//   sdram_dq   inout  SDRAM data bus, driven only while wr_sdram_en=1
// ---------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    sdram_arbit_if.slave    bus,
    inout  wire  [DQ_W-1:0] sdram_dq
);

    arb_state_e r_state;
    arb_state_e w_next;
    logic       r_aref_en;
    logic       r_wr_en;
    logic       r_rd_en;
    sdram_cmd_t w_cmd;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    // Requests are only looked at in ARBIT; *_end only in the matching state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.init_end) w_next = ST_ARBIT;
            ST_ARBIT: begin
                if      (bus.aref_req) w_next = ST_AREF;
                else if (bus.wr_req)   w_next = ST_WRITE;
                else if (bus.rd_req)   w_next = ST_READ;
            end
            ST_AREF:  if (bus.aref_end) w_next = ST_ARBIT;
            ST_WRITE: if (bus.wr_end)   w_next = ST_ARBIT;
            ST_READ:  if (bus.rd_end)   w_next = ST_ARBIT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Grants are registered decodes of the next state, so they rise on the
    // edge entering a stage and fall on the edge that samples its *_end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_aref_en <= (w_next == ST_AREF);
            r_wr_en   <= (w_next == ST_WRITE);
            r_rd_en   <= (w_next == ST_READ);
        end
    end

    // Illegal encodings fall to the init bundle for their single cycle.
    always_comb begin
        w_cmd = mk_cmd(bus.init_cmd, bus.init_ba, bus.init_addr);
        case (r_state)
            ST_ARBIT: w_cmd = ARBIT_BUNDLE;
            ST_AREF:  w_cmd = mk_cmd(bus.aref_cmd, bus.aref_ba, bus.aref_addr);
            ST_WRITE: w_cmd = mk_cmd(bus.wr_cmd, bus.wr_ba, bus.wr_addr);
            ST_READ:  w_cmd = mk_cmd(bus.rd_cmd, bus.rd_ba, bus.rd_addr);
            default:  ;
        endcase
    end

    assign bus.aref_en   = r_aref_en;
    assign bus.wr_en     = r_wr_en;
    assign bus.rd_en     = r_rd_en;
    assign bus.sdram_cke = 1'b1;
    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = w_cmd.cmd;
    assign bus.sdram_ba   = w_cmd.ba;
    assign bus.sdram_addr = w_cmd.addr;

    assign sdram_dq = bus.wr_sdram_en ? bus.wr_sdram_data : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
// Directed scenarios followed by randomized traffic. The reference model
// tracks only "has init been seen" and "which stage owns the bus", and
// derives expected grants and pin values from that.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int O_NONE = 0, O_AREF = 1, O_WR = 2, O_RD = 3;

    logic            sys_clk;
    logic            sys_rst_n;
    logic [DQ_W-1:0] dq_drv;
    wire  [DQ_W-1:0] sdram_dq;
    int              checks = 0;
    int              fails  = 0;
    bit              m_init;
    int              m_own;

    sdram_arbit_if bus();

    sdram_arbit dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .sdram_dq  (sdram_dq)
    );

    // Stand-in for the SDRAM driving read data whenever the arbiter lets go.
    wire dq_drv_en = ~bus.wr_sdram_en;
    assign sdram_dq = dq_drv_en ? dq_drv : {DQ_W{1'bz}};

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] grants();
        return {bus.aref_en, bus.wr_en, bus.rd_en};
    endfunction

    function automatic logic [16:0] pins();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                bus.sdram_ba, bus.sdram_addr};
    endfunction

    function automatic logic [2:0] exp_grants();
        return {m_own == O_AREF, m_own == O_WR, m_own == O_RD};
    endfunction

    function automatic logic [16:0] exp_pins();
        if (!m_init) return {bus.init_cmd, bus.init_ba, bus.init_addr};
        case (m_own)
            O_AREF:  return {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
            O_WR:    return {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
            O_RD:    return {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
            default: return {4'b0111, 2'b11, 11'h7ff};
        endcase
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        if (!m_init) begin
            m_init = bus.init_end;
        end else if (m_own == O_NONE) begin
            if      (bus.aref_req) m_own = O_AREF;
            else if (bus.wr_req)   m_own = O_WR;
            else if (bus.rd_req)   m_own = O_RD;
        end else if ((m_own == O_AREF && bus.aref_end) ||
                     (m_own == O_WR   && bus.wr_end)   ||
                     (m_own == O_RD   && bus.rd_end)) begin
            m_own = O_NONE;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":grant"}, 32'(grants()), 32'(exp_grants()));
        chk({tag, ":pins"},  32'(pins()),   32'(exp_pins()));
        chk({tag, ":cke"},   32'(bus.sdram_cke), 32'd1);
        if (bus.wr_sdram_en) chk({tag, ":dq_wr"}, 32'(sdram_dq), 32'(bus.wr_sdram_data));
        else                 chk({tag, ":dq_z"},  32'(sdram_dq), 32'(dq_drv));
    endtask

    task automatic cyc(input string tag);
        @(posedge sys_clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Called just after an edge; asserts reset between edges and releases it
    // on the following falling edge, with init_end dropped.
    task automatic do_reset(input string tag);
        #2;
        sys_rst_n    = 1'b0;
        bus.init_end = 1'b0;
        m_init       = 1'b0;
        m_own        = O_NONE;
        #1;
        check_all(tag);
        chk({tag, ":no_grant"}, 32'(grants()), 32'd0);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        m_init    = 1'b0;
        m_own     = O_NONE;
        dq_drv    = 16'h3C3C;
        bus.init_cmd = P_CHARGE; bus.init_ba = 2'b00; bus.init_addr = 11'h400; bus.init_end = 1'b0;
        bus.aref_req = 1'b0; bus.aref_end = 1'b0;
        bus.aref_cmd = A_REF; bus.aref_ba = 2'b01; bus.aref_addr = 11'h123;
        bus.wr_req = 1'b0; bus.wr_end = 1'b0;
        bus.wr_cmd = WRITE; bus.wr_ba = 2'b10; bus.wr_addr = 11'h055;
        bus.wr_sdram_en = 1'b0; bus.wr_sdram_data = 16'h0000;
        bus.rd_req = 1'b0; bus.rd_end = 1'b0;
        bus.rd_cmd = READ; bus.rd_ba = 2'b01; bus.rd_addr = 11'h2aa;

        // Reset state: init bundle on the pins, no grants, dq released.
        #2;
        check_all("rst");
        chk("rst_grant", 32'(grants()), 32'd0);
        chk("rst_pins", 32'(pins()), 32'({P_CHARGE, 2'b00, 11'h400}));
        #10 sys_rst_n = 1'b1;

        // init_end at cycle 10 -> ARBIT with NOP on the pins.
        repeat (9) cyc("pre_init");
        bus.init_end = 1'b1;
        cyc("init");
        chk("arbit_nop", 32'(pins()), 32'({NOP, 2'b11, 11'h7ff}));
        cyc("arbit_hold");
        chk("arbit_hold_nop", 32'(pins()), 32'({NOP, 2'b11, 11'h7ff}));

        // Refresh beats write; ARBIT one cycle between grants.
        bus.aref_req = 1'b1; bus.wr_req = 1'b1;
        cyc("prio");
        chk("prio_aref", 32'(grants()), 32'b100);
        chk("prio_pins", 32'(pins()), 32'({A_REF, 2'b01, 11'h123}));
        bus.aref_req = 1'b0; bus.aref_end = 1'b1;
        cyc("aref_end");
        chk("aref_end_gap", 32'(grants()), 32'b000);
        bus.aref_end = 1'b0;
        cyc("wr_grant");
        chk("wr_grant", 32'(grants()), 32'b010);

        // Data bus driven only with wr_sdram_en.
        bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'hA5A5;
        cyc("wr_dq");
        chk("wr_dq_a5", 32'(sdram_dq), 32'h0000A5A5);
        bus.wr_sdram_en = 1'b0;
        #1;
        chk("wr_dq_rel", 32'(sdram_dq), 32'h00003C3C);
        bus.wr_end = 1'b1; bus.wr_req = 1'b0;
        cyc("wr_end");
        bus.wr_end = 1'b0;

        // Read holds against a later refresh request.
        bus.rd_req = 1'b1;
        cyc("rd_grant");
        chk("rd_grant", 32'(grants()), 32'b001);
        bus.aref_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("rd_hold");
            chk("rd_hold", 32'(grants()), 32'b001);
        end
        bus.rd_end = 1'b1;
        cyc("rd_end");
        chk("rd_end_gap", 32'(grants()), 32'b000);
        bus.rd_end = 1'b0; bus.rd_req = 1'b0;
        cyc("aref_after_rd");
        chk("aref_after_rd", 32'(grants()), 32'b100);

        // Stray ends in AREF are ignored.
        bus.wr_end = 1'b1;
        cyc("stray_wr_end");
        chk("stray_wr_end", 32'(grants()), 32'b100);
        bus.wr_end = 1'b0; bus.rd_end = 1'b1;
        cyc("stray_rd_end");
        chk("stray_rd_end", 32'(grants()), 32'b100);
        bus.rd_end = 1'b0;

        // Reset mid-refresh; no grant until init_end is seen again.
        do_reset("rst_mid_aref");
        for (int i = 0; i < 3; i++) begin
            cyc("post_rst");
            chk("post_rst_no_grant", 32'(grants()), 32'b000);
        end
        bus.init_end = 1'b1;
        cyc("reinit");
        chk("reinit_arbit", 32'(grants()), 32'b000);
        cyc("reinit_aref");
        chk("reinit_aref", 32'(grants()), 32'b100);
        bus.aref_req = 1'b0; bus.aref_end = 1'b1;
        cyc("reinit_aref_end");
        bus.aref_end = 1'b0;

        // Random traffic, stray ends and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (!bus.init_end) bus.init_end = ($urandom_range(0, 3) == 0);
            bus.aref_req  = ($urandom_range(0, 3) == 0);
            bus.wr_req    = 1'($urandom);
            bus.rd_req    = 1'($urandom);
            bus.aref_end  = ($urandom_range(0, 4) == 0);
            bus.wr_end    = ($urandom_range(0, 4) == 0);
            bus.rd_end    = ($urandom_range(0, 4) == 0);
            bus.init_cmd  = 4'($urandom); bus.init_ba = 2'($urandom); bus.init_addr = 11'($urandom);
            bus.aref_cmd  = 4'($urandom); bus.aref_ba = 2'($urandom); bus.aref_addr = 11'($urandom);
            bus.wr_cmd    = 4'($urandom); bus.wr_ba   = 2'($urandom); bus.wr_addr   = 11'($urandom);
            bus.rd_cmd    = 4'($urandom); bus.rd_ba   = 2'($urandom); bus.rd_addr   = 11'($urandom);
            bus.wr_sdram_en   = 1'($urandom);
            bus.wr_sdram_data = 16'($urandom);
            dq_drv            = ~bus.wr_sdram_data;
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 sys_clk  in  1  100 MHz system clock; all state changes on rising edge.
REQ-002 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 init_cmd, init_ba, init_addr  in  4/2/11  init-stage command bundle {cs_n,ras_n,cas_n,we_n}, bank, A10-A0.
REQ-004 init_end  in  1  initialisation complete; level, stays high until reset.
REQ-005 aref_req  in  1  refresh request; level, held until refresh FSM acknowledges.
REQ-006 aref_cmd, aref_ba, aref_addr  in  4/2/11  refresh command bundle.
REQ-007 aref_end  in  1  one-cycle pulse; refresh sequence finished.
REQ-008 wr_req, wr_end  in  1/1  write request level; write-burst-finished pulse.
REQ-009 wr_cmd, wr_ba, wr_addr  in  4/2/11  write command bundle.
REQ-010 wr_sdram_en, wr_sdram_data  in  1/16  drive-enable and data for sdram_dq.
REQ-011 rd_req, rd_end  in  1/1  read request level; read-burst-finished pulse.
REQ-012 rd_cmd, rd_ba, rd_addr  in  4/2/11  read command bundle.
REQ-013 aref_en, wr_en, rd_en  out  1 each  grant to refresh/write/read stage.
REQ-014 sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  SDRAM control pins.
REQ-015 sdram_ba, sdram_addr  out  2/11  SDRAM bank and address pins.
REQ-016 sdram_dq  inout  16  SDRAM data bus.

Function
REQ-017 FSM states SHALL be IDLE, ARBIT, AREF, WRITE, READ; one state register.
REQ-018 IDLE -> ARBIT on the first edge with init_end=1; otherwise hold.
REQ-019 ARBIT priority SHALL be aref_req > wr_req > rd_req, to AREF/WRITE/READ respectively; no request: hold.
REQ-020 AREF -> ARBIT on edge sampling aref_end=1; WRITE -> ARBIT on wr_end=1; READ -> ARBIT on rd_end=1; no preemption of an active grant.
REQ-021 ARBIT SHALL last at least one cycle between consecutive grants (no back-to-back grant without ARBIT).
REQ-022 aref_en/wr_en/rd_en SHALL be registered: set on the edge entering AREF/WRITE/READ, cleared on the edge sampling the matching *_end; at most one high at any time.
REQ-023 Command mux (combinational on state): IDLE -> init bundle; AREF -> aref bundle; WRITE -> wr bundle; READ -> rd bundle; ARBIT -> NOP 4'b0111, ba 2'b11, addr 11'h7ff.
REQ-024 {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} SHALL equal the selected 4-bit cmd.
REQ-025 sdram_cke SHALL be constant 1.
REQ-026 sdram_dq SHALL equal wr_sdram_data when wr_sdram_en=1, else high-impedance.
REQ-027 A request deasserting while ARBIT is resolving has no effect; arbitration samples only in ARBIT.
REQ-028 *_end pulses arriving in a non-matching state SHALL be ignored.
REQ-029 Unused/illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-030 On sys_rst_n=0: state IDLE; aref_en, wr_en, rd_en = 0; outputs follow the init bundle; sdram_dq high-impedance.
REQ-031 Reset asserted mid-grant SHALL abort immediately; init_end must be re-seen before any grant.

Structure
REQ-032 Shared package sdram_pkg SHALL hold command codes (NOP 4'b0111, P_CHARGE 4'b0010, A_REF 4'b0001, ACTIVE, WRITE, READ, M_REG_SET, B_STOP), arbiter state encoding, and widths (BA 2, ADDR 11, DQ 16).
REQ-033 No sub-module required; command mux and tristate stay inline.

Verification
REQ-034 Reset then init_end=1 at cycle 10 -> state ARBIT at cycle 11; outputs NOP/ba 11/addr 7ff while no request.
REQ-035 aref_req and wr_req both high in ARBIT -> aref_en=1 next edge, wr_en=0; aref_end pulse -> aref_en=0, ARBIT one cycle, then wr_en=1.
REQ-036 wr_req in WRITE with wr_sdram_en=1, data 16'hA5A5 -> sdram_dq=16'hA5A5; wr_sdram_en=0 -> dq=Z.
REQ-037 aref_req rises while READ active -> rd_en stays 1 until rd_end; AREF entered after one ARBIT cycle.
REQ-038 Reset pulsed mid-AREF -> aref_en=0 immediately; no grant until init_end re-sampled.
REQ-039 Stray wr_end pulse in AREF -> state and aref_en unchanged.
